// File: rtl/nibble_serial_tx_if.sv
// Handshake and serial-line bundle for nibble_serial_tx.
// The master side supplies data and load; the slave side is the transmitter.
interface nibble_serial_tx_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] d;
  logic              load;
  logic              ready;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (output d, load, input ready, tx, busy, done);
  modport slave  (input d, load, output ready, tx, busy, done);
endinterface

// File: rtl/nibble_serial_tx.sv
// Serialises a parallel word as an async-style frame: start, data LSB-first,
// optional even parity, stop. Each bit is held for CLKS_PER_BIT clocks.
module nibble_serial_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic               clk,
  input  logic               reset,
  nibble_serial_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic              par_q;
  logic              tx_q;
  logic              ready_q;
  logic              done_q;
  logic              bit_end;

  assign shift_d = shift_q >> 1;
  assign bit_end = (cnt_q == CNT_LAST);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      // NOTE: the shift register is small, so it is cleared with the rest of
      // the state; a real memory array would be left unreset.
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE) cnt_q <= bit_end ? '0 : cnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (bus.load) begin
            shift_q <= bus.d;
            par_q   <= ^bus.d;
            idx_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (idx_q == IDX_LAST) begin
              if (PARITY_EN != 0) begin
                tx_q    <= par_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              shift_q <= shift_d;
              tx_q    <= shift_d[0];
              idx_q   <= idx_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          // Leaving STOP lands in IDLE with ready already high, so a load in
          // the done cycle starts the next frame with no idle gap.
          if (bit_end) begin
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.busy  = ~ready_q;
  assign bus.done  = done_q;

endmodule
